mii_frame_gen: RTL
==================

Name: mii_frame_gen

Overview:
Parametrised frame source that replaces the fixed ROM-and-free-running-counter transmit path.
- Holds one frame body in a writable byte buffer and streams it as MII nibbles, low nibble first, into mii_frame; mii_frame adds the preamble and FCS.
- Supports single-shot or periodic repeat, a programmable length, an enforced minimum inter-frame gap and a frame counter.
- Sits in the tx_clk domain between the host/loader logic and mii_frame.

Parameters:
MEM_BYTES, 128, buffer depth in bytes; power of two, 64..2048
AW, $clog2(MEM_BYTES), byte address width
LEN_W, AW+1, width of the length field, so that MEM_BYTES itself is representable
PER_W, 20, width of the repeat-period counter, in clk cycles
MIN_GAP, 32, minimum idle cycles (txdv=0) between frames; covers mii_frame's FCS and IFG overhead

Ports:
clk  in  1  tx nibble clock (ETH0_MII_tx_clk at top level)
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe
wr_addr  in  AW  buffer byte address
wr_data  in  8  buffer byte
start  in  1  one-cycle request to start sending
len  in  LEN_W  frame body length in bytes; sampled with start
repeat_en  in  1  level; when high, the frame restarts automatically every period cycles
period  in  PER_W  repeat interval in cycles, measured start-to-start; sampled with start
busy  out  1  high from start acceptance until the end of the gap of the last frame
txd  out  4  nibble to mii_frame
txdv  out  1  nibble valid to mii_frame
frame_done  out  1  one-cycle pulse on the cycle after the last nibble
frames_sent  out  16  count of completed frames; wraps

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the latched len, period and repeat state are cleared. Buffer contents are not reset. Reset asserted mid-frame drops txdv to 0 asynchronously, truncating the frame; this is accepted.
- Buffer: synchronous 1R1W block RAM with 1-cycle read latency. Writes are accepted in any state.
  - Read and write to the same address in the same cycle: the read returns the old data (read-first).
  - A write to a byte not yet fetched in the current frame is transmitted.
- FSM states: IDLE, PREFETCH, SEND, GAP.
  - IDLE: on start with 1 <= len <= MEM_BYTES, latch len, period and repeat_en. Then: busy=1, reset the nibble index to 0, go to PREFETCH.
  - IDLE, start with len=0 or len>MEM_BYTES: ignored; no busy, no pulse.
  - PREFETCH: one cycle for the RAM read of byte 0, then go to SEND. The first txdv=1 occurs 2 cycles after the cycle in which start was sampled.
  - SEND: emits exactly 2*len nibbles on consecutive cycles. The even index carries byte[idx/2][3:0] and the odd index carries byte[idx/2][7:4]. The next byte is fetched during the odd nibble, so there are no bubbles. txdv stays 1 continuously for the whole frame. After the last nibble go to GAP; on the next cycle frame_done=1 and frames_sent increments.
  - GAP: txdv=0. The gap length is max(MIN_GAP, period - (2*len+1)) cycles when repeat is active, else MIN_GAP. Then:
    - repeat active: go to PREFETCH with a fresh frame; the same latched len is used. Start-to-start distance = max(period, 2*len+1+MIN_GAP).
    - repeat not active: busy=0, go to IDLE.
- Deasserting repeat_en at any time clears the latched repeat state. The current frame always completes; frames are never truncated, since truncation would corrupt the FCS. The FSM then returns to IDLE after GAP.
- start while busy: ignored. len and period changes while busy take effect only at the next accepted start.
- Counters are unsigned. period=0 behaves as the minimum interval. frames_sent wraps from 0xFFFF to 0.

Decomposition:
- Package mii_pkg: state enum (IDLE, PREFETCH, SEND, GAP) and the MIN_GAP default constant. mii_frame and mii_deframe may share the package later.
- One sub-module, mii_frame_buf: parametrised 1R1W read-first byte RAM carrying the ram_style="block" attribute. The FSM and counters stay in mii_frame_gen.

Test Plan:
- Load bytes 0x21,0x43,0x65 at addr 0..2; start with len=3, repeat_en=0 -> txdv high for exactly 6 cycles, first one 2 cycles after start. txd sequence 1,2,3,4,5,6. frame_done pulses once; frames_sent=1; busy falls 32 cycles after the last nibble.
- len=0 start and len=MEM_BYTES+1 start -> no txdv, busy stays 0, frames_sent unchanged.
- repeat_en=1, len=4, period=100 -> txdv rising edges exactly 100 cycles apart over 5 frames. Same again with period=10 -> rising edges exactly 41 cycles apart (8+1+32).
- During frame 2 of a repeat run, drop repeat_en -> frame 2 completes with all 2*len nibbles, no frame 3, frames_sent=2, busy low after the gap.
- Write 0xAB to addr 3 while byte 1 is being sent with len=8 -> byte 3 transmitted as B,A. A same-cycle read/write collision on the fetched byte -> the old value is sent.
- Assert rst_n low mid-SEND -> txdv=0 immediately, frames_sent=0, busy=0. After release, a new start works and the buffer contents are intact.

Source files
------------

// File: rtl/mii_pkg.sv
// Shared definitions for the MII transmit path: FSM states and default gap length.
package mii_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        SEND     = 2'd2,
        GAP      = 2'd3
    } tx_state_e;

    localparam int MII_MIN_GAP = 32;

endpackage

// File: rtl/mii_frame_buf.sv
// Frame body buffer: 1R1W byte RAM, registered read, read-first on address collision.
module mii_frame_buf #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    (* ram_style = "block" *) logic [7:0] mem [DEPTH];

    // Both in one process so a same-address read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mii_frame_gen.sv
// Streams a buffered frame body to mii_frame as low-nibble-first MII nibbles,
// single-shot or periodic, with an enforced inter-frame gap and a frame counter.
module mii_frame_gen
    import mii_pkg::*;
#(
    parameter int MEM_BYTES = 128,
    parameter int AW        = $clog2(MEM_BYTES),
    parameter int LEN_W     = AW + 1,
    parameter int PER_W     = 20,
    parameter int MIN_GAP   = MII_MIN_GAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             repeat_en,
    input  logic [PER_W-1:0] period,
    output logic             busy,
    output logic [3:0]       txd,
    output logic             txdv,
    output logic             frame_done,
    output logic [15:0]      frames_sent
);

    tx_state_e          state, state_nx;
    logic [LEN_W-1:0]   len_q;
    logic [PER_W-1:0]   period_q;
    logic               rep_q;
    logic [LEN_W-1:0]   nib_idx;
    logic [PER_W-1:0]   gap_cnt;

    logic               len_ok, start_ok, rep_active, last_nib, gap_end;
    logic [LEN_W:0]     nib_last;
    logic [31:0]        frame_cyc, per_ext, gap_target;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [7:0]         rd_data;

    mii_frame_buf #(.DEPTH(MEM_BYTES), .AW(AW)) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign len_ok     = (len != '0) && (len <= LEN_W'(MEM_BYTES));
    assign rep_active = rep_q & repeat_en;
    assign nib_last   = {len_q, 1'b0} - (LEN_W+1)'(1);
    assign last_nib   = ({1'b0, nib_idx} == nib_last);

    // Gap is stretched so that start-to-start equals period, never below MIN_GAP.
    always_comb begin
        frame_cyc = 32'({len_q, 1'b0}) + 32'd1;
        per_ext   = 32'(period_q);
        if (rep_active && (per_ext > frame_cyc + 32'(MIN_GAP)))
            gap_target = per_ext - frame_cyc;
        else
            gap_target = 32'(MIN_GAP);
        gap_end = ((32'(gap_cnt) + 32'd1) >= gap_target);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start_ok = 1'b0;
        busy     = (state != IDLE);
        txdv     = (state == SEND);
        txd      = 4'h0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        case (state)
            IDLE: begin
                if (start && len_ok) begin
                    start_ok = 1'b1;
                    state_nx = PREFETCH;
                end
            end
            PREFETCH: begin
                rd_en    = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                txd = nib_idx[0] ? rd_data[7:4] : rd_data[3:0];
                // Next byte is fetched under the odd nibble so the stream has no bubbles.
                rd_en   = nib_idx[0] & ~last_nib;
                rd_addr = nib_idx[AW:1] + AW'(1);
                if (last_nib) state_nx = GAP;
            end
            GAP: begin
                if (gap_end) state_nx = rep_active ? PREFETCH : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            period_q    <= '0;
            rep_q       <= 1'b0;
            nib_idx     <= '0;
            gap_cnt     <= '0;
            frame_done  <= 1'b0;
            frames_sent <= '0;
        end else begin
            frame_done <= 1'b0;
            if (start_ok) begin
                len_q    <= len;
                period_q <= period;
                rep_q    <= repeat_en;
                nib_idx  <= '0;
            end else begin
                rep_q <= rep_q & repeat_en;
            end
            case (state)
                PREFETCH: nib_idx <= '0;
                SEND: begin
                    nib_idx <= nib_idx + LEN_W'(1);
                    if (last_nib) begin
                        frame_done  <= 1'b1;
                        frames_sent <= frames_sent + 16'd1;
                        gap_cnt     <= '0;
                    end
                end
                GAP:     gap_cnt <= gap_cnt + PER_W'(1);
                default: ;
            endcase
        end
    end

endmodule
